// File: rtl/click_gen.sv
// click_gen: emulates a push-button click (fast or long hold) with optional
// contact bounce on press and release, followed by a mandatory released gap.
`default_nettype none

module click_gen #(
  parameter int IN_C_HZ    = 50_000_000,
  parameter int FAST_MS    = 100,
  parameter int LONG_MS    = 1000,
  parameter int GAP_MS     = 200,
  parameter int BOUNCE_N   = 2,
  parameter int BOUNCE_CYC = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic req_fast,
  input  logic req_long,
  output logic key_out,
  output logic busy,
  output logic done
);

  localparam int FAST_CNT = FAST_MS * (IN_C_HZ / 1000);
  localparam int LONG_CNT = LONG_MS * (IN_C_HZ / 1000);
  localparam int GAP_CNT  = GAP_MS * (IN_C_HZ / 1000);
  localparam int MAX_A    = (LONG_CNT > FAST_CNT) ? LONG_CNT : FAST_CNT;
  localparam int MAX_B    = (GAP_CNT > BOUNCE_CYC) ? GAP_CNT : BOUNCE_CYC;
  localparam int MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_CNT) + 1;
  localparam int HALF_W   = $clog2(2 * BOUNCE_N + 1) + 1;
  localparam int HALF_INI = (BOUNCE_N > 0) ? 2 * BOUNCE_N - 1 : 0;

  // Segment counters are loaded with length-1 and expire when they reach zero.
  localparam logic [CNT_W-1:0]  FAST_LD = CNT_W'(FAST_CNT - 1);
  localparam logic [CNT_W-1:0]  LONG_LD = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0]  GAP_LD  = CNT_W'(GAP_CNT - 1);
  localparam logic [CNT_W-1:0]  BNC_LD  = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LD = HALF_W'(HALF_INI);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    B_ON  = 3'd1,
    HOLD  = 3'd2,
    B_OFF = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [HALF_W-1:0] half, half_n;
  logic              long_sel, long_n;
  logic              key_n, busy_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= '0;
      long_sel <= 1'b0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      half     <= half_n;
      long_sel <= long_n;
      key_out  <= key_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    half_n  = half;
    long_n  = long_sel;
    key_n   = key_out;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        key_n  = 1'b0;
        busy_n = 1'b0;
        if (req_fast || req_long) begin
          long_n = req_long;
          busy_n = 1'b1;
          key_n  = 1'b1;
          if (BOUNCE_N > 0) begin
            state_n = B_ON;
            cnt_n   = BNC_LD;
            half_n  = HALF_LD;
          end else begin
            state_n = HOLD;
            cnt_n   = req_long ? LONG_LD : FAST_LD;
          end
        end
      end
      B_ON, B_OFF: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (half != '0) begin
          half_n = half - HALF_W'(1);
          cnt_n  = BNC_LD;
          key_n  = ~key_out;
        end else if (state == B_ON) begin
          state_n = HOLD;
          cnt_n   = long_sel ? LONG_LD : FAST_LD;
          key_n   = 1'b1;
        end else begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          key_n   = 1'b0;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          key_n = 1'b0;
          if (BOUNCE_N > 0) begin
            state_n = B_OFF;
            cnt_n   = BNC_LD;
            half_n  = HALF_LD;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        key_n   = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_click_gen.sv
// tb_click_gen: directed vector table plus randomized requests against a
// waveform-queue reference model, for bounce-free and bouncing instances.
`default_nettype none

module tb_click_gen;

  localparam int HZ   = 10_000;
  localparam int FAST = 2 * (HZ / 1000);
  localparam int LONG = 6 * (HZ / 1000);
  localparam int GAPC = 1 * (HZ / 1000);
  localparam int BC   = 3;

  logic clk = 1'b0;
  logic rst, req_fast, req_long;
  logic key0, busy0, done0, key2, busy2, done2;

  int n_vec = 0;
  int n_err = 0;

  typedef logic [2:0] ent_t;  // {key, busy, done}
  typedef struct {
    int   bn;
    int   f1;
    int   f2;
    int   l1;
    int   l2;
    int   cyc;
    ent_t exp;
  } vec_t;

  vec_t tbl[$];
  ent_t tr0[0:100];
  ent_t tr2[0:100];
  ent_t q0[$], q2[$], seq[$];
  ent_t e0, e2;

  click_gen #(.IN_C_HZ(HZ), .FAST_MS(2), .LONG_MS(6), .GAP_MS(1),
              .BOUNCE_N(0), .BOUNCE_CYC(BC)) u0 (
    .clk(clk), .rst(rst), .req_fast(req_fast), .req_long(req_long),
    .key_out(key0), .busy(busy0), .done(done0));

  click_gen #(.IN_C_HZ(HZ), .FAST_MS(2), .LONG_MS(6), .GAP_MS(1),
              .BOUNCE_N(2), .BOUNCE_CYC(BC)) u2 (
    .clk(clk), .rst(rst), .req_fast(req_fast), .req_long(req_long),
    .key_out(key2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  task automatic check(input string nm, input ent_t act, input ent_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: key/busy/done got %b expected %b", nm, act, exp);
    end
  endtask

  // Whole expected waveform of one click, one entry per cycle, then the done cycle.
  function automatic void build(input int bn, input bit lng);
    seq.delete();
    for (int i = 0; i < 2 * bn; i++)
      for (int c = 0; c < BC; c++) seq.push_back((i % 2 == 0) ? 3'b110 : 3'b010);
    for (int c = 0; c < (lng ? LONG : FAST); c++) seq.push_back(3'b110);
    for (int i = 0; i < 2 * bn; i++)
      for (int c = 0; c < BC; c++) seq.push_back((i % 2 == 0) ? 3'b010 : 3'b110);
    for (int c = 0; c < GAPC; c++) seq.push_back(3'b010);
    seq.push_back(3'b001);
  endfunction

  task automatic model_reset();
    q0.delete();
    q2.delete();
    e0 = 3'b000;
    e2 = 3'b000;
  endtask

  task automatic model_step();
    if (!e0[1] && (req_fast || req_long)) begin build(0, req_long); q0 = seq; end
    if (!e2[1] && (req_fast || req_long)) begin build(2, req_long); q2 = seq; end
    e0 = (q0.size() > 0) ? q0.pop_front() : 3'b000;
    e2 = (q2.size() > 0) ? q2.pop_front() : 3'b000;
  endtask

  task automatic add(input int bn, input int f1, input int f2, input int l1,
                     input int l2, input int cyc, input ent_t exp);
    vec_t v;
    v.bn = bn; v.f1 = f1; v.f2 = f2; v.l1 = l1; v.l2 = l2; v.cyc = cyc; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Reset, then drive requests; trace[n] holds the outputs during cycle n.
  task automatic run(input int f1, input int f2, input int l1, input int l2);
    rst = 1'b1; req_fast = 1'b0; req_long = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    tr0[0] = {key0, busy0, done0};
    tr2[0] = {key2, busy2, done2};
    for (int n = 0; n < 100; n++) begin
      req_fast = (n == f1) || (n == f2);
      req_long = (n == l1) || (n == l2);
      @(posedge clk); #1;
      tr0[n+1] = {key0, busy0, done0};
      tr2[n+1] = {key2, busy2, done2};
      @(negedge clk);
    end
    req_fast = 1'b0;
    req_long = 1'b0;
  endtask

  initial begin
    ent_t acc;
    rst = 1'b1; req_fast = 1'b0; req_long = 1'b0;
    model_reset();

    add(0, 0, -1, -1, -1,  0, 3'b000);
    add(0, 0, -1, -1, -1,  1, 3'b110);
    add(0, 0, -1, -1, -1, 20, 3'b110);
    add(0, 0, -1, -1, -1, 21, 3'b010);
    add(0, 0, -1, -1, -1, 30, 3'b010);
    add(0, 0, -1, -1, -1, 31, 3'b001);
    add(0, 0, -1, -1, -1, 32, 3'b000);
    add(0, 0, -1,  0, -1,  1, 3'b110);
    add(0, 0, -1,  0, -1, 60, 3'b110);
    add(0, 0, -1,  0, -1, 61, 3'b010);
    add(0, 0, -1,  0, -1, 70, 3'b010);
    add(0, 0, -1,  0, -1, 71, 3'b001);
    add(0, 0, -1,  0, -1, 72, 3'b000);
    add(2, 0, -1, -1, -1,  1, 3'b110);
    add(2, 0, -1, -1, -1,  3, 3'b110);
    add(2, 0, -1, -1, -1,  4, 3'b010);
    add(2, 0, -1, -1, -1,  7, 3'b110);
    add(2, 0, -1, -1, -1, 10, 3'b010);
    add(2, 0, -1, -1, -1, 12, 3'b010);
    add(2, 0, -1, -1, -1, 13, 3'b110);
    add(2, 0, -1, -1, -1, 32, 3'b110);
    add(2, 0, -1, -1, -1, 33, 3'b010);
    add(2, 0, -1, -1, -1, 36, 3'b110);
    add(2, 0, -1, -1, -1, 39, 3'b010);
    add(2, 0, -1, -1, -1, 44, 3'b110);
    add(2, 0, -1, -1, -1, 45, 3'b010);
    add(2, 0, -1, -1, -1, 54, 3'b010);
    add(2, 0, -1, -1, -1, 55, 3'b001);
    add(2, 0, -1, -1, -1, 56, 3'b000);
    add(2, -1, -1, 0, -1, 72, 3'b110);
    add(2, -1, -1, 0, -1, 73, 3'b010);
    add(2, -1, -1, 0, -1, 95, 3'b001);
    add(0, 0, -1,  5, 25, 20, 3'b110);
    add(0, 0, -1,  5, 25, 21, 3'b010);
    add(0, 0, -1,  5, 25, 31, 3'b001);
    add(0, 0, -1,  5, 25, 40, 3'b000);
    add(0, 0, -1,  5, 25, 61, 3'b000);
    add(0, 0, 31, -1, -1, 31, 3'b001);
    add(0, 0, 31, -1, -1, 32, 3'b110);
    add(0, 0, 31, -1, -1, 51, 3'b110);
    add(0, 0, 31, -1, -1, 52, 3'b010);
    add(0, 0, 31, -1, -1, 62, 3'b001);
    add(0, 0, 31, -1, -1, 63, 3'b000);

    #1;
    check("reset_dut0", {key0, busy0, done0}, 3'b000);
    check("reset_dut2", {key2, busy2, done2}, 3'b000);

    foreach (tbl[i]) begin
      run(tbl[i].f1, tbl[i].f2, tbl[i].l1, tbl[i].l2);
      check($sformatf("vec%0d_bn%0d_cyc%0d", i, tbl[i].bn, tbl[i].cyc),
            (tbl[i].bn == 0) ? tr0[tbl[i].cyc] : tr2[tbl[i].cyc], tbl[i].exp);
    end

    // Abort a long click mid-hold and confirm no done follows.
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      req_long = (n == 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("abort_pre_cyc30", {key0, busy0, done0}, 3'b110);
    rst = 1'b1;
    #1;
    check("abort_async", {key0, busy0, done0}, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    acc = 3'b000;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      acc = acc | {key0, busy0, done0};
      @(negedge clk);
    end
    check("abort_no_done", acc, 3'b000);
    for (int n = 0; n < 40; n++) begin
      req_fast = (n == 0);
      @(posedge clk); #1;
      tr0[n+1] = {key0, busy0, done0};
      @(negedge clk);
    end
    req_fast = 1'b0;
    check("after_abort_c1", tr0[1], 3'b110);
    check("after_abort_c20", tr0[20], 3'b110);
    check("after_abort_c21", tr0[21], 3'b010);
    check("after_abort_c31", tr0[31], 3'b001);

    // Randomized requests and occasional resets against the queue model.
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; req_fast = 1'b0; req_long = 1'b0;
        model_reset();
        #1;
        check("rand_rst0", {key0, busy0, done0}, e0);
        check("rand_rst2", {key2, busy2, done2}, e2);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      req_fast = ($urandom_range(0, 24) == 0);
      req_long = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
      model_step();
      check($sformatf("rand0_i%0d", i), {key0, busy0, done0}, e0);
      check($sformatf("rand2_i%0d", i), {key2, busy2, done2}, e2);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/click_gen.md
CLICK_GEN -- requirements
Module: click_gen

Interface
REQ-001 The block SHALL have parameter IN_C_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter FAST_MS, default 100, key-hold time of a fast click in ms.
REQ-003 The block SHALL have parameter LONG_MS, default 1000, key-hold time of a long click in ms.
REQ-004 The block SHALL have parameter GAP_MS, default 200, mandatory key-released time after each click in ms.
REQ-005 The block SHALL have parameter BOUNCE_N, default 2, number of contact-bounce pulses emulated on press and on release; 0 disables bounce.
REQ-006 The block SHALL have parameter BOUNCE_CYC, default 5000, clock cycles per bounce half-period.
REQ-007 clk  input  1  clock, all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 req_fast  input  1  one-cycle request to emit a fast click.
REQ-010 req_long  input  1  one-cycle request to emit a long click.
REQ-011 key_out  output  1  emulated key line, 1 = pressed, registered.
REQ-012 busy  output  1  high while a click sequence is in progress, registered.
REQ-013 done  output  1  one-cycle pulse on sequence completion, registered.

Function
REQ-014 Cycle counts SHALL be FAST_CNT = FAST_MS*(IN_C_HZ/1000), LONG_CNT = LONG_MS*(IN_C_HZ/1000), GAP_CNT = GAP_MS*(IN_C_HZ/1000), computed at elaboration.
REQ-015 A single down/up counter SHALL be sized $clog2 of the largest of LONG_CNT, FAST_CNT, GAP_CNT, BOUNCE_CYC, plus 1 bit; no wrap-around SHALL occur for legal parameters.
REQ-016 FSM states SHALL be IDLE, B_ON, HOLD, B_OFF, GAP.
REQ-017 IDLE: key_out=0, busy=0; on req_long or req_fast sampled high, go to B_ON (or HOLD if BOUNCE_N=0), latch hold length, busy=1 and key_out=1 from the next cycle.
REQ-018 Simultaneous req_fast and req_long in IDLE SHALL produce a long click.
REQ-019 Requests while busy=1 (including the done cycle's preceding GAP cycles) SHALL be ignored, not queued.
REQ-020 B_ON: key_out SHALL alternate 1 for BOUNCE_CYC cycles, 0 for BOUNCE_CYC cycles, BOUNCE_N times, then enter HOLD.
REQ-021 HOLD: key_out=1 for exactly FAST_CNT or LONG_CNT cycles, then B_OFF (or GAP if BOUNCE_N=0).
REQ-022 B_OFF: key_out SHALL alternate 0 for BOUNCE_CYC, 1 for BOUNCE_CYC, BOUNCE_N times, then GAP.
REQ-023 GAP: key_out=0 for GAP_CNT cycles, then IDLE.
REQ-024 On the first IDLE cycle after GAP, done=1 for one cycle and busy=0; a request sampled in that cycle SHALL be accepted.
REQ-025 done SHALL never assert outside that cycle; key_out SHALL have no glitches (registered only).

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, counter=0, key_out=0, busy=0, done=0, including mid-sequence; no done pulse SHALL follow an aborted sequence.
REQ-027 After rst release, the first request SHALL be accepted on the first rising edge at which it is sampled.

Verification (IN_C_HZ=10_000, FAST_MS=2, LONG_MS=6, GAP_MS=1; cycle 0 = edge sampling the request)
REQ-028 BOUNCE_N=0, req_fast at cycle 0 -> key_out=1 cycles 1-20, 0 from 21; busy 1-30; done=1 at cycle 31 only.
REQ-029 BOUNCE_N=0, req_long and req_fast together at 0 -> key_out=1 cycles 1-60; done at 71.
REQ-030 BOUNCE_N=2, BOUNCE_CYC=3, req_fast at 0 -> key_out 111000111000 (cycles 1-12), 1 for 13-32, 000111000111 (33-44), 0 for 45-54, done at 55.
REQ-031 BOUNCE_N=0, req_fast at 0, req_long at 5 and 25 -> second request ignored, single 20-cycle click, done at 31.
REQ-032 BOUNCE_N=0, req_long at 0, rst pulse at cycle 30 -> key_out, busy 0 asynchronously, no done; new req_fast after release -> normal 20-cycle click.
REQ-033 BOUNCE_N=0, req_fast at 0 and at 31 -> second click key_out=1 cycles 32-51, done at 62.
